// File: rtl/code_round_ctrl_if.sv
// Player/RNG-facing signal bundle for code_round_ctrl.
// slave = controller side, master = driver side (RNG + player input + observer).
interface code_round_ctrl_if;
  logic        start;
  logic [19:0] random_num;
  logic        digit_valid;
  logic [3:0]  digit_in;
  logic        digit_ready;
  logic [2:0]  digit_idx;
  logic [19:0] entered;
  logic [19:0] target;
  logic [4:0]  match_mask;
  logic [2:0]  hits;
  logic        result_valid;
  logic [3:0]  attempts;
  logic        digit_err;
  logic        round_done;
  logic        win;

  modport slave (
    input  start, random_num, digit_valid, digit_in,
    output digit_ready, digit_idx, entered, target, match_mask, hits,
           result_valid, attempts, digit_err, round_done, win
  );

  modport master (
    output start, random_num, digit_valid, digit_in,
    input  digit_ready, digit_idx, entered, target, match_mask, hits,
           result_valid, attempts, digit_err, round_done, win
  );
endinterface

// File: rtl/code_round_ctrl.sv
// Code-guessing round controller: latches a 5-digit BCD secret, collects guesses, scores them.
// Optional macro CODE_ROUND_BACKSPACE_EN makes digit 4'hF act as backspace during entry.
module code_round_ctrl #(
  parameter int unsigned MAX_ATTEMPTS = 4
) (
  input  logic          clk,
  input  logic          rst,
  code_round_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ENTRY, CHECK, DONE} state_t;

  state_t      state;
  logic        digit_ready_q, result_valid_q, digit_err_q, round_done_q, win_q;
  logic [2:0]  idx_q, hits_q;
  logic [19:0] entered_q, target_q;
  logic [4:0]  mask_q;
  logic [3:0]  attempts_q;

  logic [4:0]  mask_c;
  logic [2:0]  hits_c;
  logic [19:0] target_c;
  logic [4:0]  slot_lsb, prev_lsb;

  // digit 0 lives in the top nibble, so slot k starts at bit 4*(4-k)
  assign slot_lsb = {3'd4 - idx_q, 2'b00};
  assign prev_lsb = {3'd5 - idx_q, 2'b00};

  always_comb begin
    mask_c   = '0;
    hits_c   = '0;
    target_c = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      mask_c[i] = (entered_q[4*i +: 4] == target_q[4*i +: 4]);
      hits_c    = hits_c + 3'(mask_c[i]);
      target_c[4*i +: 4] = (bus.random_num[4*i +: 4] > 4'd9) ? 4'd9
                                                               : bus.random_num[4*i +: 4];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      digit_ready_q  <= 1'b0;
      result_valid_q <= 1'b0;
      digit_err_q    <= 1'b0;
      round_done_q   <= 1'b0;
      win_q          <= 1'b0;
      idx_q          <= '0;
      hits_q         <= '0;
      entered_q      <= '0;
      target_q       <= '0;
      mask_q         <= '0;
      attempts_q     <= '0;
    end else begin
      result_valid_q <= 1'b0;
      digit_err_q    <= 1'b0;
      if (bus.start) begin
        target_q      <= target_c;
        entered_q     <= '0;
        idx_q         <= '0;
        attempts_q    <= '0;
        mask_q        <= '0;
        hits_q        <= '0;
        win_q         <= 1'b0;
        round_done_q  <= 1'b0;
        digit_ready_q <= 1'b1;
        state         <= ENTRY;
      end else begin
        case (state)
          ENTRY: begin
            if (bus.digit_valid) begin
              if (bus.digit_in <= 4'd9) begin
                entered_q[slot_lsb +: 4] <= bus.digit_in;
                if (idx_q == 3'd4) begin
                  idx_q         <= '0;
                  digit_ready_q <= 1'b0;
                  state         <= CHECK;
                end else begin
                  idx_q <= idx_q + 3'd1;
                end
              end
`ifdef CODE_ROUND_BACKSPACE_EN
              else if (bus.digit_in == 4'hF) begin
                if (idx_q != 3'd0) begin
                  idx_q                    <= idx_q - 3'd1;
                  entered_q[prev_lsb +: 4] <= 4'd0;
                end
              end
`endif
              else begin
                digit_err_q <= 1'b1;
              end
            end
          end
          CHECK: begin
            mask_q         <= mask_c;
            hits_q         <= hits_c;
            result_valid_q <= 1'b1;
            if (attempts_q != 4'(MAX_ATTEMPTS))
              attempts_q <= attempts_q + 4'd1;
            if (hits_c == 3'd5) begin
              win_q        <= 1'b1;
              round_done_q <= 1'b1;
              state        <= DONE;
            end else if (attempts_q + 4'd1 == 4'(MAX_ATTEMPTS)) begin
              win_q        <= 1'b0;
              round_done_q <= 1'b1;
              state        <= DONE;
            end else begin
              entered_q     <= '0;
              digit_ready_q <= 1'b1;
              state         <= ENTRY;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifndef CODE_ROUND_BACKSPACE_EN
  logic unused_prev;
  assign unused_prev = ^prev_lsb;
`endif

  assign bus.digit_ready  = digit_ready_q;
  assign bus.digit_idx    = idx_q;
  assign bus.entered      = entered_q;
  assign bus.target       = target_q;
  assign bus.match_mask   = mask_q;
  assign bus.hits         = hits_q;
  assign bus.result_valid = result_valid_q;
  assign bus.attempts     = attempts_q;
  assign bus.digit_err    = digit_err_q;
  assign bus.round_done   = round_done_q;
  assign bus.win          = win_q;
endmodule

// File: tb/tb_code_round_ctrl.sv
// Self-checking bench for code_round_ctrl: directed scenarios plus random rounds vs a digit-array model.
module tb_code_round_ctrl;
  localparam int MAXA = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  code_round_ctrl_if bus();

  code_round_ctrl #(.MAX_ATTEMPTS(MAXA)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // model: one int per digit position, position 0 entered first
  int m_tgt[5];
  int m_ent[5];
  int m_idx, m_att, m_hits;
  bit m_entry, m_done, m_win;
  logic [4:0] m_mask;

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] pack_ent();
    logic [19:0] v = '0;
    for (int i = 0; i < 5; i++) v = v * 16 + 20'(m_ent[i]);
    return v;
  endfunction

  function automatic logic [19:0] pack_tgt();
    logic [19:0] v = '0;
    for (int i = 0; i < 5; i++) v = v * 16 + 20'(m_tgt[i]);
    return v;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, ".ready"}, 20'(bus.digit_ready), 20'd0);
    chk({tag, ".idx"}, 20'(bus.digit_idx), 20'd0);
    chk({tag, ".entered"}, bus.entered, 20'd0);
    chk({tag, ".target"}, bus.target, 20'd0);
    chk({tag, ".mask"}, 20'(bus.match_mask), 20'd0);
    chk({tag, ".hits"}, 20'(bus.hits), 20'd0);
    chk({tag, ".rv"}, 20'(bus.result_valid), 20'd0);
    chk({tag, ".att"}, 20'(bus.attempts), 20'd0);
    chk({tag, ".err"}, 20'(bus.digit_err), 20'd0);
    chk({tag, ".done"}, 20'(bus.round_done), 20'd0);
    chk({tag, ".win"}, 20'(bus.win), 20'd0);
  endtask

  task automatic do_start(input logic [19:0] rn, input bit with_digit);
    bus.start = 1'b1;
    bus.random_num = rn;
    if (with_digit) begin
      bus.digit_valid = 1'b1;
      bus.digit_in = 4'd5;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.digit_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      int nib = int'((rn >> (4 * (4 - i))) & 20'hF);
      m_tgt[i] = (nib > 9) ? 9 : nib;
      m_ent[i] = 0;
    end
    m_idx = 0; m_att = 0; m_entry = 1; m_done = 0; m_win = 0;
    chk("start.target", bus.target, pack_tgt());
    chk("start.entered", bus.entered, 20'd0);
    chk("start.idx", 20'(bus.digit_idx), 20'd0);
    chk("start.att", 20'(bus.attempts), 20'd0);
    chk("start.ready", 20'(bus.digit_ready), 20'd1);
    chk("start.done", 20'(bus.round_done), 20'd0);
    chk("start.win", 20'(bus.win), 20'd0);
    chk("start.hits", 20'(bus.hits), 20'd0);
    chk("start.mask", 20'(bus.match_mask), 20'd0);
  endtask

  task automatic send_digit(input int d);
    bit exp_err = 0;
    bit scoring = 0;
    bus.digit_valid = 1'b1;
    bus.digit_in = 4'(d);
    @(posedge clk); #1;
    bus.digit_valid = 1'b0;
    if (m_entry) begin
      if (d <= 9) begin
        m_ent[m_idx] = d;
        if (m_idx == 4) begin
          m_idx = 0; m_entry = 0; scoring = 1;
        end else m_idx++;
      end
`ifdef CODE_ROUND_BACKSPACE_EN
      else if (d == 15) begin
        if (m_idx > 0) begin
          m_idx--;
          m_ent[m_idx] = 0;
        end
      end
`endif
      else exp_err = 1;
    end
    chk("dig.err", 20'(bus.digit_err), 20'(exp_err));
    chk("dig.idx", 20'(bus.digit_idx), 20'(m_idx));
    chk("dig.entered", bus.entered, pack_ent());
    chk("dig.rv", 20'(bus.result_valid), 20'd0);
    chk("dig.ready", 20'(bus.digit_ready), 20'(m_entry));
    chk("dig.done", 20'(bus.round_done), 20'(m_done));
    chk("dig.att", 20'(bus.attempts), 20'(m_att));
    if (scoring) begin
      @(posedge clk); #1;
      m_hits = 0;
      for (int i = 0; i < 5; i++) begin
        m_mask[4 - i] = (m_ent[i] == m_tgt[i]);
        if (m_ent[i] == m_tgt[i]) m_hits++;
      end
      if (m_att < MAXA) m_att++;
      if (m_hits == 5) begin
        m_win = 1; m_done = 1;
      end else if (m_att == MAXA) begin
        m_win = 0; m_done = 1;
      end else begin
        for (int i = 0; i < 5; i++) m_ent[i] = 0;
        m_entry = 1;
      end
      chk("score.rv", 20'(bus.result_valid), 20'd1);
      chk("score.mask", 20'(bus.match_mask), 20'(m_mask));
      chk("score.hits", 20'(bus.hits), 20'(m_hits));
      chk("score.att", 20'(bus.attempts), 20'(m_att));
      chk("score.done", 20'(bus.round_done), 20'(m_done));
      chk("score.win", 20'(bus.win), 20'(m_win));
      chk("score.ready", 20'(bus.digit_ready), 20'(m_entry));
      chk("score.entered", bus.entered, pack_ent());
    end
  endtask

  initial begin
    int code[5];
    bus.start = 1'b0;
    bus.random_num = '0;
    bus.digit_valid = 1'b0;
    bus.digit_in = '0;
    m_entry = 0; m_done = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    // win on first guess
    do_start(20'h38170, 0);
    code = '{3, 8, 1, 7, 0};
    foreach (code[i]) send_digit(code[i]);
    chk("win.mask", 20'(bus.match_mask), 20'h1F);
    chk("win.flag", 20'(bus.win), 20'd1);

    // lose after MAX_ATTEMPTS
    do_start(20'h12345, 0);
    code = '{1, 2, 9, 9, 5};
    for (int g = 0; g < MAXA; g++) foreach (code[i]) send_digit(code[i]);
    chk("lose.mask", 20'(bus.match_mask), 20'h19);
    chk("lose.att", 20'(bus.attempts), 20'(MAXA));
    chk("lose.win", 20'(bus.win), 20'd0);
    send_digit(4);
    send_digit(15);

    // invalid digits at idx 2
    do_start(20'h12345, 0);
    send_digit(1); send_digit(2);
    send_digit(10);
    chk("inv.idx", 20'(bus.digit_idx), 20'd2);
    send_digit(15);

    // clamp of non-BCD nibbles
    do_start(20'hB0F09, 0);
    chk("clamp.target", bus.target, 20'h90909);

    // restart mid-entry, then start colliding with a digit
    send_digit(1); send_digit(2); send_digit(3);
    do_start(20'h55555, 0);
    chk("restart.target", bus.target, 20'h55555);
    send_digit(7);
    do_start(20'h24680, 1);

    // asynchronous reset mid-entry
    send_digit(2); send_digit(4);
    #2 rst = 1'b1;
    #1;
    chk_zero("arst");
    m_entry = 0; m_done = 0; m_att = 0; m_idx = 0;
    foreach (m_ent[i]) m_ent[i] = 0;
    @(negedge clk);
    rst = 1'b0;
    send_digit(3);

    // backspace sequence (F is an invalid digit when the feature is off)
    do_start(20'h47123, 0);
    send_digit(4); send_digit(6); send_digit(15);
`ifdef CODE_ROUND_BACKSPACE_EN
    chk("bs.idx", 20'(bus.digit_idx), 20'd1);
    chk("bs.entered", bus.entered, 20'h40000);
`endif
    code = '{7, 1, 2, 3, 0};
    for (int i = 0; i < 4; i++) send_digit(code[i]);
    send_digit(15);
    send_digit(15);

    // random rounds
    for (int r = 0; r < 10; r++) begin
      do_start(20'($urandom), 0);
      for (int k = 0; k < 80 && !m_done; k++) begin
        if ($urandom_range(0, 2) != 0) send_digit(m_tgt[m_idx]);
        else send_digit(int'($urandom_range(0, 15)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
